datactrl: RTL

Memory-side data controller of the out-of-order core. It accepts committed store requests from the reorder buffer and load requests from the load buffer. It arbitrates between them and serialises each access into byte transfers on the single-byte RAM port. It returns a one-cycle completion pulse to the requester, with sign- or zero-extended data for loads.

---
 rtl/datactrl_if.sv | 46 ++++
 rtl/datactrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/datactrl_if.sv
// Request/response and RAM-port bundle for the data controller.
// master : requester + RAM side (drives requests and mem_din, observes done pulses and RAM cmds)
// slave  : the controller (consumes requests and mem_din, drives done pulses and RAM cmds)
interface datactrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  // Store port (reorder buffer)
  logic                  rob_datactrl_en_in;
  logic [ADDR_WIDTH-1:0] rob_datactrl_addr_in;
  logic [2:0]            rob_datactrl_width_in;
  logic [DATA_WIDTH-1:0] rob_datactrl_data_in;
  logic                  datactrl_rob_en_out;
  // Load port (load buffer)
  logic                  lbuffer_datactrl_en_in;
  logic [ADDR_WIDTH-1:0] lbuffer_datactrl_addr_in;
  logic [2:0]            lbuffer_datactrl_width_in;
  logic                  lbuffer_datactrl_signed_in;
  logic                  datactrl_lbuffer_en_out;
  logic [DATA_WIDTH-1:0] datactrl_lbuffer_data_out;
  // Byte-wide RAM port
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr_out;

  modport master (
    output rob_datactrl_en_in, rob_datactrl_addr_in, rob_datactrl_width_in, rob_datactrl_data_in,
    input  datactrl_rob_en_out,
    output lbuffer_datactrl_en_in, lbuffer_datactrl_addr_in, lbuffer_datactrl_width_in,
    output lbuffer_datactrl_signed_in,
    input  datactrl_lbuffer_en_out, datactrl_lbuffer_data_out,
    output mem_din,
    input  mem_dout, mem_a, mem_wr_out
  );

  modport slave (
    input  rob_datactrl_en_in, rob_datactrl_addr_in, rob_datactrl_width_in, rob_datactrl_data_in,
    output datactrl_rob_en_out,
    input  lbuffer_datactrl_en_in, lbuffer_datactrl_addr_in, lbuffer_datactrl_width_in,
    input  lbuffer_datactrl_signed_in,
    output datactrl_lbuffer_en_out, datactrl_lbuffer_data_out,
    input  mem_din,
    output mem_dout, mem_a, mem_wr_out
  );
endinterface

// File: rtl/datactrl.sv
// Memory-side data controller: arbitrates committed stores against loads and serialises each
// access into byte transfers on a single-byte RAM port. Returns one-cycle done pulses, with
// sign/zero-extended data for loads.
// Ports:
//   clk_in      clock
//   rst_in      synchronous active-high reset
//   rdy_in      global enable; low freezes all state and forces mem_wr_out low
//   rob_rst_in  misprediction flush; aborts the in-flight or latched load only
//   bus         datactrl_if.slave: store/load request ports and byte RAM port
module datactrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     rob_rst_in,
  datactrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StStore, StLoad, StLoadTail} state_e;

  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;  // index of the next byte to issue

  // Request slots; width encoding doubles as the byte count
  logic                  st_pend_q, st_pend_d;
  logic [ADDR_WIDTH-1:0] st_addr_q, st_addr_d;
  logic [2:0]            st_n_q, st_n_d;
  logic [DATA_WIDTH-1:0] st_data_q, st_data_d;
  logic                  ld_pend_q, ld_pend_d;
  logic [ADDR_WIDTH-1:0] ld_addr_q, ld_addr_d;
  logic [2:0]            ld_n_q, ld_n_d;
  logic                  ld_signed_q, ld_signed_d;

  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  rob_done_q, rob_done_d;
  logic                  ld_done_q, ld_done_d;
  logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;

  function automatic logic width_ok(logic [2:0] w);
    return (w == 3'b001) || (w == 3'b010) || (w == 3'b100);
  endfunction

  logic st_new, ld_new, sel_ok, start_st, start_ld, st_last, ld_last;
  logic [ADDR_WIDTH-1:0] st_eff_addr, ld_eff_addr;
  logic [DATA_WIDTH-1:0] st_eff_data, ld_word, ld_ext;
  logic [1:0] cap_lane, tail_lane;

  assign st_new = bus.rob_datactrl_en_in && width_ok(bus.rob_datactrl_width_in);
  // A load arriving together with a flush is discarded
  assign ld_new = bus.lbuffer_datactrl_en_in && width_ok(bus.lbuffer_datactrl_width_in) &&
                  !rob_rst_in;
  // The done-pulse cycle never selects, so a queued request starts one cycle later
  assign sel_ok   = (state_q == StIdle) && !rob_done_q && !ld_done_q;
  assign start_st = sel_ok && (st_pend_q || st_new);
  assign start_ld = sel_ok && !start_st && ((ld_pend_q && !rob_rst_in) || ld_new);
  assign st_last  = (cnt_q == st_n_q);
  assign ld_last  = (cnt_q == ld_n_q);

  assign st_eff_addr = st_new ? bus.rob_datactrl_addr_in : st_addr_q;
  assign st_eff_data = st_new ? bus.rob_datactrl_data_in : st_data_q;
  assign ld_eff_addr = ld_new ? bus.lbuffer_datactrl_addr_in : ld_addr_q;

  // Byte read back this cycle belongs to the address issued in the previous cycle
  assign cap_lane  = 2'(cnt_q - 3'd2);
  assign tail_lane = 2'(ld_n_q - 3'd1);

  // State register (with all other state)
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      st_pend_q   <= 1'b0;
      st_addr_q   <= '0;
      st_n_q      <= '0;
      st_data_q   <= '0;
      ld_pend_q   <= 1'b0;
      ld_addr_q   <= '0;
      ld_n_q      <= '0;
      ld_signed_q <= 1'b0;
      buf_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      rob_done_q  <= 1'b0;
      ld_done_q   <= 1'b0;
      ld_data_q   <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_pend_q   <= st_pend_d;
      st_addr_q   <= st_addr_d;
      st_n_q      <= st_n_d;
      st_data_q   <= st_data_d;
      ld_pend_q   <= ld_pend_d;
      ld_addr_q   <= ld_addr_d;
      ld_n_q      <= ld_n_d;
      ld_signed_q <= ld_signed_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      rob_done_q  <= rob_done_d;
      ld_done_q   <= ld_done_d;
      ld_data_q   <= ld_data_d;
    end
  end

  // Next state and request slots
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_st)      state_d = StStore;
        else if (start_ld) state_d = StLoad;
      end
      StStore:    if (st_last) state_d = StIdle;
      StLoad: begin
        if (rob_rst_in)   state_d = StIdle;
        else if (ld_last) state_d = StLoadTail;
      end
      StLoadTail: state_d = StIdle;
      default:    state_d = StIdle;
    endcase

    st_pend_d = st_pend_q;
    st_addr_d = st_addr_q;
    st_n_d    = st_n_q;
    st_data_d = st_data_q;
    if (st_new) begin
      st_pend_d = 1'b1;
      st_addr_d = bus.rob_datactrl_addr_in;
      st_n_d    = bus.rob_datactrl_width_in;
      st_data_d = bus.rob_datactrl_data_in;
    end else if (state_q == StStore && st_last) begin
      st_pend_d = 1'b0;
    end

    ld_pend_d   = ld_pend_q;
    ld_addr_d   = ld_addr_q;
    ld_n_d      = ld_n_q;
    ld_signed_d = ld_signed_q;
    if (rob_rst_in) begin
      ld_pend_d = 1'b0;
    end else if (ld_new) begin
      ld_pend_d   = 1'b1;
      ld_addr_d   = bus.lbuffer_datactrl_addr_in;
      ld_n_d      = bus.lbuffer_datactrl_width_in;
      ld_signed_d = bus.lbuffer_datactrl_signed_in;
    end else if (state_q == StLoadTail) begin
      ld_pend_d = 1'b0;
    end
  end

  // Datapath and registered outputs
  always_comb begin
    ld_word = buf_q;
    ld_word[{tail_lane, 3'b000} +: 8] = bus.mem_din;
    case (ld_n_q)
      3'b001:  ld_ext = {{(DATA_WIDTH-8){ld_signed_q & ld_word[7]}}, ld_word[7:0]};
      3'b010:  ld_ext = {{(DATA_WIDTH-16){ld_signed_q & ld_word[15]}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase

    cnt_d      = cnt_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    rob_done_d = 1'b0;
    ld_done_d  = 1'b0;
    ld_data_d  = ld_data_q;
    unique case (state_q)
      StIdle: begin
        if (start_st) begin
          mem_a_d    = st_eff_addr;
          mem_dout_d = st_eff_data[7:0];
          mem_wr_d   = 1'b1;
          cnt_d      = 3'd1;
        end else if (start_ld) begin
          mem_a_d = ld_eff_addr;
          buf_d   = '0;
          cnt_d   = 3'd1;
        end
      end
      StStore: begin
        if (!st_last) begin
          mem_a_d    = st_addr_q + ADDR_WIDTH'(cnt_q);
          mem_dout_d = st_data_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end else begin
          rob_done_d = 1'b1;
        end
      end
      StLoad: begin
        if (!rob_rst_in) begin
          if (cnt_q >= 3'd2) buf_d[{cap_lane, 3'b000} +: 8] = bus.mem_din;
          if (!ld_last) begin
            mem_a_d = ld_addr_q + ADDR_WIDTH'(cnt_q);
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end
      StLoadTail: begin
        if (!rob_rst_in) begin
          buf_d     = ld_word;
          ld_data_d = ld_ext;
          ld_done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_a                     = mem_a_q;
  assign bus.mem_dout                  = mem_dout_q;
  assign bus.mem_wr_out                = mem_wr_q && rdy_in;
  // Held pulses surface only once the block is enabled again
  assign bus.datactrl_rob_en_out       = rob_done_q && rdy_in;
  assign bus.datactrl_lbuffer_en_out   = ld_done_q && rdy_in;
  assign bus.datactrl_lbuffer_data_out = ld_data_q;

endmodule
